axi4_lite_lstm_loader: RTL

AXI4-Lite write-master sequencer that loads LSTM weight/bias words into the LSTM layers block's AXI4-Lite slave port. It accepts a word stream from a host-side source (DMA, ROM reader, UART bridge). It issues one single-beat write per word to consecutive word addresses and reports completion and response errors. It sits between the weight source and the slave write channels; the slave read channel is not driven by this block.

---
 rtl/axi4_lite_lstm_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/axi4_lite_lstm_loader.sv
// AXI4-Lite write-master sequencer: streams LSTM weight/bias words into consecutive
// word addresses of the LSTM block's slave port, one single-beat write at a time.
module axi4_lite_lstm_loader #(
    parameter int          WIDTH     = 32,
    parameter int          DEPTH     = 512,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int         ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [WIDTH-1:0]      s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [31:0]           awaddr,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [WIDTH-1:0]      wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   err_count
);

    // state | meaning
    // IDLE  | waiting for start
    // FETCH | s_ready high, waiting for next stream word
    // WRITE | awvalid/wvalid presented, each drops after its own handshake
    // RESP  | bready high, waiting for the write response
    // DONE  | final cycle of the load; done pulses on the way back to IDLE

    typedef enum logic [2:0] {IDLE, FETCH, WRITE, RESP, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

    state_t              state;
    logic [ADDR_WIDTH:0] count;
    logic [ADDR_WIDTH:0] index;
    logic [ADDR_WIDTH:0] wc_clamped;
    logic                aw_ok;
    logic                w_ok;

    assign wc_clamped = (word_count > DEPTH_W) ? DEPTH_W : word_count;
    assign awprot     = 3'b000;
    assign wstrb      = 4'b1111;

    // A channel is finished once its valid has dropped or is handshaking this cycle.
    assign aw_ok = !awvalid || awready;
    assign w_ok  = !wvalid  || wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            index     <= '0;
            s_ready   <= 1'b0;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count     <= wc_clamped;
                        index     <= '0;
                        error     <= 1'b0;
                        err_count <= '0;
                        busy      <= 1'b1;
                        if (wc_clamped != '0) begin
                            state   <= FETCH;
                            s_ready <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                FETCH: begin
                    if (s_valid) begin
                        wdata   <= s_data;
                        awaddr  <= BASE_ADDR + 32'({index, 2'b00});
                        s_ready <= 1'b0;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        bready <= 1'b1;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        index  <= index + ONE;
                        if (bresp != 2'b00) begin
                            error     <= 1'b1;
                            err_count <= err_count + ONE;
                        end
                        if (index == count - ONE) begin
                            state <= DONE;
                        end else begin
                            state   <= FETCH;
                            s_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
